inst_cache: RTL and testbench

//  Direct-mapped, read-only instruction cache; responder to the Fetcher's inst_req/inst_handle/inst_ready protocol.

---
 rtl/inst_cache.sv | 152 +++++++++++++++
 tb/tb_inst_cache.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache between the Fetcher and the memory controller.
// Hits answer two cycles after the request; misses fill the whole line word by word first.
module inst_cache #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_handle,
  output logic        inst_ready,
  output logic [31:0] inst_out,
  input  logic        rob_clear,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;
  localparam int TAG_LSB  = OFFSET_BITS + INDEX_BITS + 2;
  localparam int TAG_BITS = 32 - TAG_LSB;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_FILL   = 2'd2;

  logic [31:0]             r_data [LINES*WORDS];
  logic [TAG_BITS-1:0]     r_tag  [LINES];
  logic [LINES-1:0]        r_valid;
  logic [31:0]             r_rd_word;
  logic [TAG_BITS-1:0]     r_rd_tag;

  logic [1:0]              r_state;
  logic [31:0]             r_addr;
  logic [OFFSET_BITS-1:0]  r_cnt;
  logic                    r_drop;
  logic [31:0]             r_fill_word;
  logic                    r_handle;
  logic                    r_ready;
  logic [31:0]             r_out;
  logic                    r_mem_req;
  logic [31:0]             r_mem_addr;

  logic [INDEX_BITS-1:0]   w_req_index;
  logic [OFFSET_BITS-1:0]  w_req_word;
  logic [INDEX_BITS-1:0]   w_index;
  logic [OFFSET_BITS-1:0]  w_word;
  logic [TAG_BITS-1:0]     w_tag;
  logic                    w_hit;
  logic                    w_fill_we;
  logic                    w_fill_last;

  assign w_req_index = inst_addr[TAG_LSB-1:OFFSET_BITS+2];
  assign w_req_word  = inst_addr[OFFSET_BITS+1:2];
  assign w_index     = r_addr[TAG_LSB-1:OFFSET_BITS+2];
  assign w_word      = r_addr[OFFSET_BITS+1:2];
  assign w_tag       = r_addr[31:TAG_LSB];
  assign w_hit       = r_valid[w_index] && (r_rd_tag == w_tag);
  assign w_fill_we   = rdy_in && (r_state == S_FILL) && mem_ready;
  assign w_fill_last = (r_cnt == OFFSET_BITS'(WORDS - 1));

  assign inst_handle = r_handle;
  assign inst_ready  = r_ready;
  assign inst_out    = r_out;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;

  // Arrays are read one edge ahead, on the IDLE edge that accepts the request.
  always_ff @(posedge clk_in) begin
    if (rdy_in && (r_state == S_IDLE)) begin
      r_rd_word <= r_data[{w_req_index, w_req_word}];
      r_rd_tag  <= r_tag[w_req_index];
    end
    if (w_fill_we) begin
      r_data[{w_index, r_cnt}] <= mem_data;
      if (w_fill_last) begin
        r_tag[w_index] <= w_tag;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_valid     <= '0;
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_drop      <= 1'b0;
      r_fill_word <= '0;
      r_handle    <= 1'b0;
      r_ready     <= 1'b0;
      r_out       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
    end else if (rdy_in) begin
      r_handle <= 1'b0;
      r_ready  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (inst_req && !rob_clear) begin
            r_addr   <= inst_addr;
            r_handle <= 1'b1;
            r_state  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (rob_clear) begin
            r_state <= S_IDLE;
          end else if (w_hit) begin
            r_out   <= r_rd_word;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= {w_tag, w_index, {OFFSET_BITS{1'b0}}, 2'b00};
            r_cnt      <= '0;
            r_drop     <= 1'b0;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (rob_clear) begin
            r_drop <= 1'b1;
          end
          if (mem_ready) begin
            r_cnt      <= r_cnt + 1'b1;
            r_mem_addr <= r_mem_addr + 32'd4;
            // Keep the requested word aside so the answer needs no array read mid-fill.
            if (r_cnt == w_word) begin
              r_fill_word <= mem_data;
            end
            if (w_fill_last) begin
              r_mem_req        <= 1'b0;
              r_valid[w_index] <= 1'b1;
              r_state          <= S_IDLE;
              if (!r_drop && !rob_clear) begin
                r_ready <= 1'b1;
                r_out   <= (w_word == r_cnt) ? mem_data : r_fill_word;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed table, reset/stall corner cases, then random
// requests checked against a line-level cache model and a fixed memory image.
module tb_inst_cache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_handle;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic        rob_clear;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;

  inst_cache dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_handle(inst_handle),
    .inst_ready (inst_ready),
    .inst_out   (inst_out),
    .rob_clear  (rob_clear),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_data   (mem_data)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_out = 32'd0;
  bit          m_valid [64];
  logic [21:0] m_tag   [64];
  logic [31:0] rd_log  [$];
  int          wait_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    int          clr_mode;   // 0 none, 1 clear during lookup, 2 clear after 2nd fill word
    bit          exp_hit;
    logic [31:0] exp_word;
  } vec_t;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h1000 && a <= 32'h100C) return 32'hA0 + ((a - 32'h1000) >> 2);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory responder: random latency, one word per handshake, logs every address served.
  initial begin
    mem_ready = 1'b0;
    mem_data  = 32'd0;
    forever begin
      @(negedge clk_in);
      mem_ready = 1'b0;
      if (mem_req && rdy_in && !rst_in) begin
        if (wait_cnt == 0) begin
          mem_ready = 1'b1;
          mem_data  = mem_word(mem_addr);
          rd_log.push_back(mem_addr);
          wait_cnt  = $urandom_range(0, 2);
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  task automatic xact(input logic [31:0] addr, input int clr_mode, input bit exp_hit,
                      input logic [31:0] exp_word);
    bit did_clear = 0;
    bit clear_on  = 0;
    bit early     = 0;
    bit done      = 0;
    logic [31:0] base;
    base = {addr[31:4], 4'b0000};
    rd_log.delete();
    @(negedge clk_in);
    inst_req  = 1'b1;
    inst_addr = addr;
    @(posedge clk_in); #1;
    inst_req = 1'b0;
    chk("handle", {31'd0, inst_handle}, 32'd1);
    chk("ready_with_handle", {31'd0, inst_ready}, 32'd0);
    if (clr_mode == 1) rob_clear = 1'b1;
    @(posedge clk_in); #1;
    if (clr_mode == 1) begin
      rob_clear = 1'b0;
      chk("clr_lookup_ready", {31'd0, inst_ready}, 32'd0);
      chk("clr_lookup_memreq", {31'd0, mem_req}, 32'd0);
      chk("clr_lookup_out", inst_out, exp_out);
    end else if (exp_hit) begin
      chk("hit_memreq", {31'd0, mem_req}, 32'd0);
      chk("hit_ready", {31'd0, inst_ready}, 32'd1);
      chk("hit_handle_low", {31'd0, inst_handle}, 32'd0);
      chk("hit_out", inst_out, exp_word);
      exp_out = exp_word;
    end else begin
      chk("miss_memreq", {31'd0, mem_req}, 32'd1);
      chk("miss_memaddr", mem_addr, base);
      for (int c = 0; c < 100; c++) begin
        @(posedge clk_in); #1;
        if (clear_on) begin
          rob_clear = 1'b0;
          clear_on  = 0;
        end
        if (!mem_req) begin
          done = 1;
          break;
        end
        if (inst_ready) early = 1;
        if (clr_mode == 2 && !did_clear && rd_log.size() == 2) begin
          rob_clear = 1'b1;
          did_clear = 1;
          clear_on  = 1;
        end
      end
      rob_clear = 1'b0;
      chk("fill_timeout", {31'd0, done}, 32'd1);
      chk("fill_early_ready", {31'd0, early}, 32'd0);
      chk("fill_words", rd_log.size(), 32'd4);
      for (int i = 0; i < rd_log.size() && i < 4; i++)
        chk("fill_addr", rd_log[i], base + 32'(4 * i));
      chk("fill_ready", {31'd0, inst_ready}, {31'd0, !did_clear});
      if (!did_clear) exp_out = exp_word;
      chk("fill_out", inst_out, exp_out);
      m_valid[addr[9:4]] = 1;
      m_tag[addr[9:4]]   = addr[31:10];
    end
    $display("xact addr=%h mode=%0d hit=%0d out=%h", addr, clr_mode, exp_hit, inst_out);
  endtask

  vec_t vecs [10];
  logic [31:0] a;
  int          mode;
  bit          h;

  initial begin
    vecs[0] = '{32'h1000, 0, 1'b0, 32'hA0};
    vecs[1] = '{32'h100C, 0, 1'b1, 32'hA3};
    vecs[2] = '{32'h1400, 0, 1'b0, mem_word(32'h1400)};
    vecs[3] = '{32'h1404, 0, 1'b1, mem_word(32'h1404)};
    vecs[4] = '{32'h1000, 0, 1'b0, 32'hA0};
    vecs[5] = '{32'h2000, 2, 1'b0, mem_word(32'h2000)};
    vecs[6] = '{32'h2004, 0, 1'b1, mem_word(32'h2004)};
    vecs[7] = '{32'h3008, 1, 1'b0, mem_word(32'h3008)};
    vecs[8] = '{32'h3008, 0, 1'b0, mem_word(32'h3008)};
    vecs[9] = '{32'h300C, 0, 1'b1, mem_word(32'h300C)};
    for (int i = 0; i < 64; i++) m_valid[i] = 0;

    rst_in = 1'b1; rdy_in = 1'b1; inst_req = 1'b0; inst_addr = 32'd0; rob_clear = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(posedge clk_in); #1;
    chk("rst_handle", {31'd0, inst_handle}, 32'd0);
    chk("rst_ready", {31'd0, inst_ready}, 32'd0);
    chk("rst_out", inst_out, 32'd0);
    chk("rst_memreq", {31'd0, mem_req}, 32'd0);
    chk("rst_memaddr", mem_addr, 32'd0);

    for (int i = 0; i < 10; i++) xact(vecs[i].addr, vecs[i].clr_mode, vecs[i].exp_hit, vecs[i].exp_word);

    // Asynchronous reset in the middle of a fill.
    rd_log.delete();
    @(negedge clk_in);
    inst_req = 1'b1; inst_addr = 32'h5000;
    @(posedge clk_in); #1;
    inst_req = 1'b0;
    for (int c = 0; c < 50 && rd_log.size() < 1; c++) @(posedge clk_in);
    @(posedge clk_in); #3;
    rst_in = 1'b1;
    #1;
    chk("arst_memreq", {31'd0, mem_req}, 32'd0);
    chk("arst_memaddr", mem_addr, 32'd0);
    chk("arst_out", inst_out, 32'd0);
    chk("arst_ready", {31'd0, inst_ready}, 32'd0);
    chk("arst_handle", {31'd0, inst_handle}, 32'd0);
    #1 rst_in = 1'b0;
    for (int i = 0; i < 64; i++) m_valid[i] = 0;
    exp_out = 32'd0;
    $display("xact async reset during fill of 5000");
    xact(32'h5000, 0, 1'b0, mem_word(32'h5000));

    // Stall a lookup hit for three cycles.
    @(negedge clk_in);
    inst_req = 1'b1; inst_addr = 32'h5004;
    @(posedge clk_in); #1;
    inst_req = 1'b0;
    rdy_in   = 1'b0;
    chk("stall_handle", {31'd0, inst_handle}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_in); #1;
      chk("stall_ready", {31'd0, inst_ready}, 32'd0);
      chk("stall_out", inst_out, exp_out);
    end
    rdy_in = 1'b1;
    @(posedge clk_in); #1;
    chk("stall_release_ready", {31'd0, inst_ready}, 32'd1);
    chk("stall_release_handle", {31'd0, inst_handle}, 32'd0);
    chk("stall_release_out", inst_out, mem_word(32'h5004));
    exp_out = mem_word(32'h5004);
    $display("xact addr=00005004 stalled hit out=%h", inst_out);

    // Random requests over a few conflicting lines, checked against the model.
    for (int i = 0; i < 80; i++) begin
      a = 32'h8000 + (32'($urandom_range(0, 3)) << 10) + (32'($urandom_range(0, 3)) << 4)
          + (32'($urandom_range(0, 3)) << 2);
      h = m_valid[a[9:4]] && (m_tag[a[9:4]] == a[31:10]);
      mode = ($urandom_range(0, 5) == 0) ? 1 : (($urandom_range(0, 4) == 0) ? 2 : 0);
      if (h && mode == 2) mode = 0;
      xact(a, mode, h, mem_word(a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
